// File: rtl/bank_mpregfile_nrmw.sv
// -----------------------------------------------------------------------------
// bank_mpregfile_nrmw
//
// Multi-ported register file for the issue/register-read stage. It has NR
// combinational read ports, NW write ports and NBANK address-interleaved banks.
// Each bank has a single write port. A write that collides with an older write
// to the same bank in the same cycle is deferred to a small in-order pending
// queue. The queue drains one entry per cycle and is bypassed to the read ports.
// After reset, an init sweep writes zero to every entry before writes are
// accepted.
//
// Ports:
//   clk          clock
//   rst          asynchronous, active-high reset
//   ra_i         NR read addresses, port k at [k*AW +: AW]
//   rd_o         NR read data, combinational from ra_i, port k at [k*WIDTH +: WIDTH]
//   we_i         NW write enables (port 0 is oldest in program order)
//   wa_i         NW write addresses
//   wd_i         NW write data
//   ready_o      writes presented this cycle are accepted
//   init_busy_o  init sweep in progress
//   drop_o       one-cycle pulse: a write was presented while ready_o was low
//   pend_cnt_o   pending-queue occupancy
//
// Build option:
//   ZERO_REG_EN  when defined, register 0 is hardwired to zero. Writes to it are
//                discarded, and reads of it return 0 without bypass.
// -----------------------------------------------------------------------------
module bank_mpregfile_nrmw #(
    parameter  int unsigned WIDTH      = 32,
    parameter  int unsigned DEPTH      = 32,
    parameter  int unsigned NR         = 6,
    parameter  int unsigned NW         = 2,
    parameter  int unsigned NBANK      = 2,
    parameter  int unsigned PEND_DEPTH = 4,
    localparam int unsigned AW         = $clog2(DEPTH),
    localparam int unsigned PCW        = $clog2(PEND_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NR*AW-1:0]      ra_i,
    output logic [NR*WIDTH-1:0]   rd_o,
    input  logic [NW-1:0]         we_i,
    input  logic [NW*AW-1:0]      wa_i,
    input  logic [NW*WIDTH-1:0]   wd_i,
    output logic                  ready_o,
    output logic                  init_busy_o,
    output logic                  drop_o,
    output logic [PCW-1:0]        pend_cnt_o
);

    localparam int unsigned ENT = DEPTH / NBANK;
    localparam int unsigned BW  = $clog2(NBANK);
    localparam int unsigned LW  = (AW > BW) ? (AW - BW) : 1;
    localparam int unsigned PW  = $clog2(PEND_DEPTH);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    // ------------------------------------------------------------------------
    // Address helpers: the low address bits select the bank, and the remaining
    // bits index within it.
    // ------------------------------------------------------------------------
    function automatic logic [BW-1:0] bank_of(input logic [AW-1:0] a);
        return a[BW-1:0];
    endfunction

    function automatic logic [LW-1:0] idx_of(input logic [AW-1:0] a);
        return LW'(a >> BW);
    endfunction

    // Circular pointer advance. PEND_DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int unsigned n);
        int unsigned s;
        s = 32'(p) + n;
        if (s >= PEND_DEPTH) begin
            s = s - PEND_DEPTH;
        end
        return PW'(s);
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t              state_q,    state_d;
    logic [LW-1:0]       init_cnt_q, init_cnt_d;
    logic [PW-1:0]       head_q,     head_d;
    logic [PW-1:0]       tail_q,     tail_d;
    logic [PCW-1:0]      cnt_q,      cnt_d;
    logic                drop_q,     drop_d;

    logic [AW-1:0]       pq_addr_q [PEND_DEPTH];
    logic [AW-1:0]       pq_addr_d [PEND_DEPTH];
    logic [WIDTH-1:0]    pq_data_q [PEND_DEPTH];
    logic [WIDTH-1:0]    pq_data_d [PEND_DEPTH];

    // Bank storage. It has no reset; the init sweep zeroes it.
    logic [WIDTH-1:0]    mem [NBANK][ENT];

    // One write per bank per cycle, from the sweep, a direct write or the drain.
    logic [NBANK-1:0]    bank_we;
    logic [LW-1:0]       bank_idx [NBANK];
    logic [WIDTH-1:0]    bank_wd  [NBANK];

    logic                ready;

    // Occupancy is a registered value, so ready has no path from the write inputs.
    assign ready       = (state_q == ST_RUN) && (cnt_q <= PCW'(PEND_DEPTH - NW));
    assign ready_o     = ready;
    assign init_busy_o = (state_q == ST_INIT);
    assign drop_o      = drop_q;
    assign pend_cnt_o  = cnt_q;

    // ------------------------------------------------------------------------
    // Next-state, write steering and queue update
    // ------------------------------------------------------------------------
    always_comb begin : p_next
        logic [AW-1:0]    wa_p;
        logic [WIDTH-1:0] wd_p;
        logic             we_p;
        logic [BW-1:0]    hb;
        logic [NBANK-1:0] claimed;
        logic [PW-1:0]    slot;
        int unsigned      n_enq;
        int unsigned      pop;

        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        head_d     = head_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;
        drop_d     = (|we_i) && !ready;
        pq_addr_d  = pq_addr_q;
        pq_data_d  = pq_data_q;
        bank_we    = '0;
        for (int unsigned b = 0; b < NBANK; b++) begin
            bank_idx[b] = '0;
            bank_wd[b]  = '0;
        end
        wa_p    = '0;
        wd_p    = '0;
        we_p    = 1'b0;
        hb      = '0;
        claimed = '0;
        slot    = tail_q;
        n_enq   = 0;
        pop     = 0;

        unique case (state_q)
            ST_INIT: begin
                for (int unsigned b = 0; b < NBANK; b++) begin
                    bank_we[b]  = 1'b1;
                    bank_idx[b] = init_cnt_q;
                    bank_wd[b]  = '0;
                end
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == LW'(ENT - 1)) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // Drain the head. Direct writes happen only when the queue is
                // empty, so the head's bank is always free here.
                if (cnt_q != '0) begin
                    hb           = bank_of(pq_addr_q[head_q]);
                    bank_we[hb]  = 1'b1;
                    bank_idx[hb] = idx_of(pq_addr_q[head_q]);
                    bank_wd[hb]  = pq_data_q[head_q];
                    head_d       = ptr_add(head_q, 1);
                    pop          = 1;
                end

                // Accept writes in port (program) order. With a non-empty queue,
                // every write enqueues so it stays behind the older deferred
                // writes. Enqueue slots start at tail_q, independent of the pop.
                for (int unsigned p = 0; p < NW; p++) begin
                    wa_p = wa_i[p*AW +: AW];
                    wd_p = wd_i[p*WIDTH +: WIDTH];
                    we_p = we_i[p] && ready;
`ifdef ZERO_REG_EN
                    if (wa_p == '0) begin
                        we_p = 1'b0;
                    end
`endif
                    if (we_p) begin
                        if ((cnt_q == '0) && !claimed[bank_of(wa_p)]) begin
                            claimed[bank_of(wa_p)]  = 1'b1;
                            bank_we[bank_of(wa_p)]  = 1'b1;
                            bank_idx[bank_of(wa_p)] = idx_of(wa_p);
                            bank_wd[bank_of(wa_p)]  = wd_p;
                        end else begin
                            pq_addr_d[slot] = wa_p;
                            pq_data_d[slot] = wd_p;
                            slot            = ptr_add(slot, 1);
                            n_enq           = n_enq + 1;
                        end
                    end
                end
                tail_d = slot;
                cnt_d  = PCW'(32'(cnt_q) + n_enq - pop);
            end

            default: state_d = ST_INIT;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            drop_q     <= drop_d;
        end
    end

    // Queue payload needs no reset: entries outside [head, head+cnt) are never read.
    always_ff @(posedge clk) begin
        pq_addr_q <= pq_addr_d;
        pq_data_q <= pq_data_d;
    end

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < NBANK; b++) begin
            if (bank_we[b]) begin
                mem[b][bank_idx[b]] <= bank_wd[b];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read ports: bank mux, then a bypass from the pending queue. The walk runs
    // from oldest to newest, so the newest matching entry wins.
    // ------------------------------------------------------------------------
    always_comb begin : p_read
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] val;
        logic [PW-1:0]    pos;

        rd_o = '0;
        a    = '0;
        val  = '0;
        pos  = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            a   = ra_i[k*AW +: AW];
            val = mem[bank_of(a)][idx_of(a)];
            for (int unsigned i = 0; i < PEND_DEPTH; i++) begin
                pos = ptr_add(head_q, i);
                if ((PCW'(i) < cnt_q) && (pq_addr_q[pos] == a)) begin
                    val = pq_data_q[pos];
                end
            end
            if (state_q == ST_INIT) begin
                val = '0;
            end
`ifdef ZERO_REG_EN
            if (a == '0) begin
                val = '0;
            end
`endif
            rd_o[k*WIDTH +: WIDTH] = val;
        end
    end

endmodule

// File: tb/tb_bank_mpregfile_nrmw.sv
module tb_bank_mpregfile_nrmw;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned DEPTH      = 32;
    localparam int unsigned NR         = 6;
    localparam int unsigned NW         = 2;
    localparam int unsigned NBANK      = 2;
    localparam int unsigned PEND_DEPTH = 4;
    localparam int unsigned AW         = 5;
    localparam int unsigned PCW        = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NR*AW-1:0]      ra_i;
    logic [NR*WIDTH-1:0]   rd_o;
    logic [NW-1:0]         we_i;
    logic [NW*AW-1:0]      wa_i;
    logic [NW*WIDTH-1:0]   wd_i;
    logic                  ready_o;
    logic                  init_busy_o;
    logic                  drop_o;
    logic [PCW-1:0]        pend_cnt_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    bank_mpregfile_nrmw #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .NR         (NR),
        .NW         (NW),
        .NBANK      (NBANK),
        .PEND_DEPTH (PEND_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ra_i        (ra_i),
        .rd_o        (rd_o),
        .we_i        (we_i),
        .wa_i        (wa_i),
        .wd_i        (wd_i),
        .ready_o     (ready_o),
        .init_busy_o (init_busy_o),
        .drop_o      (drop_o),
        .pend_cnt_o  (pend_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Combinational read on one port; takes 1 time unit.
    task automatic rdp(input int unsigned port, input logic [AW-1:0] a, output logic [WIDTH-1:0] d);
        ra_i[port*AW +: AW] = a;
        #1;
        d = rd_o[port*WIDTH +: WIDTH];
    endtask

    task automatic wr(input logic [1:0] we, input logic [AW-1:0] a0, input logic [WIDTH-1:0] d0,
                      input logic [AW-1:0] a1, input logic [WIDTH-1:0] d1);
        we_i = we;
        wa_i = {a1, a0};
        wd_i = {d1, d0};
    endtask

    task automatic idle();
        we_i = '0;
        wa_i = '0;
        wd_i = '0;
    endtask

    // Count the cycles spent in the sweep, from the reset-release negedge onward.
    task automatic wait_init(output int unsigned n);
        n = 0;
        while (init_busy_o && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] d;
        int unsigned      n;
        logic [AW-1:0]    ra_tab [8];
        logic [WIDTH-1:0] rd_tab [8];

        rst  = 1'b1;
        ra_i = '0;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", ready_o, 0);
        chk("rst_busy", init_busy_o, 1);
        chk("rst_drop", drop_o, 0);
        chk("rst_cnt", pend_cnt_o, 0);
        chk("rst_rd", |rd_o, 0);

        // Sweep length and contents
        rst = 1'b0;
        wait_init(n);
        chk("init_len", n, 16);
        chk("run_ready", ready_o, 1);
        for (int i = 0; i < 32; i++) begin
            rdp(i % NR, AW'(i), d);
            chk($sformatf("zero_r%0d", i), d, 0);
        end
        @(negedge clk);

        // Different banks: both go directly to the RAM, not visible until next cycle
        wr(2'b11, 5'd4, 32'hAAAA, 5'd7, 32'hBBBB);
        rdp(0, 5'd4, d);
        chk("no_fwd_r4", d, 0);
        @(negedge clk);
        idle();
        chk("diff_cnt", pend_cnt_o, 0);
        rdp(0, 5'd4, d);
        chk("diff_r4", d, 32'hAAAA);
        rdp(1, 5'd7, d);
        chk("diff_r7", d, 32'hBBBB);
        @(negedge clk);

        // Same bank: port 1 is deferred and read back through the bypass
        wr(2'b11, 5'd2, 32'h11, 5'd6, 32'h22);
        @(negedge clk);
        idle();
        chk("same_cnt1", pend_cnt_o, 1);
        rdp(2, 5'd6, d);
        chk("same_byp_r6", d, 32'h22);
        rdp(3, 5'd2, d);
        chk("same_r2", d, 32'h11);
        @(negedge clk);
        chk("same_cnt0", pend_cnt_o, 0);
        rdp(4, 5'd6, d);
        chk("same_ram_r6", d, 32'h22);
        @(negedge clk);

        // Same address on both ports: the younger value wins
        wr(2'b11, 5'd9, 32'h1, 5'd9, 32'h2);
        @(negedge clk);
        idle();
        chk("dup_cnt1", pend_cnt_o, 1);
        rdp(5, 5'd9, d);
        chk("dup_byp_r9", d, 32'h2);
        @(negedge clk);
        chk("dup_cnt0", pend_cnt_o, 0);
        rdp(0, 5'd9, d);
        chk("dup_ram_r9", d, 32'h2);
        @(negedge clk);

        // Back-to-back same-bank pairs fill the queue until ready drops
        wr(2'b11, 5'd10, 32'h100, 5'd12, 32'h101);
        @(negedge clk);
        chk("bb_cnt_a", pend_cnt_o, 1);
        chk("bb_ready_a", ready_o, 1);
        wr(2'b11, 5'd14, 32'h102, 5'd16, 32'h103);
        @(negedge clk);
        chk("bb_cnt_b", pend_cnt_o, 2);
        chk("bb_ready_b", ready_o, 1);
        wr(2'b11, 5'd18, 32'h104, 5'd20, 32'h105);
        @(negedge clk);
        chk("bb_cnt_c", pend_cnt_o, 3);
        chk("bb_ready_c", ready_o, 0);
        chk("bb_drop_c", drop_o, 0);
        rdp(0, 5'd20, d);
        chk("bb_byp_r20", d, 32'h105);
        wr(2'b11, 5'd22, 32'h1FF, 5'd24, 32'h1FE);
        @(negedge clk);
        idle();
        chk("bb_cnt_d", pend_cnt_o, 2);
        chk("bb_drop_d", drop_o, 1);
        @(negedge clk);
        chk("bb_drop_e", drop_o, 0);
        chk("bb_cnt_e", pend_cnt_o, 1);
        @(negedge clk);
        chk("bb_cnt_f", pend_cnt_o, 0);
        ra_tab = '{5'd10, 5'd12, 5'd14, 5'd16, 5'd18, 5'd20, 5'd22, 5'd24};
        rd_tab = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h0, 32'h0};
        for (int i = 0; i < 8; i++) begin
            rdp(i % NR, ra_tab[i], d);
            chk($sformatf("bb_r%0d", ra_tab[i]), d, rd_tab[i]);
        end
        @(negedge clk);

        // Register 0
        wr(2'b01, 5'd0, 32'h5, 5'd0, 32'h0);
        @(negedge clk);
        idle();
        chk("r0_cnt", pend_cnt_o, 0);
        rdp(1, 5'd0, d);
`ifdef ZERO_REG_EN
        chk("r0_zero", d, 0);
`else
        chk("r0_plain", d, 32'h5);
`endif
        @(negedge clk);

        // Reset with two queued entries discards them and restarts the sweep
        wr(2'b11, 5'd3, 32'h33, 5'd5, 32'h55);
        @(negedge clk);
        chk("q2_cnt1", pend_cnt_o, 1);
        wr(2'b11, 5'd11, 32'h77, 5'd13, 32'h88);
        @(negedge clk);
        idle();
        chk("q2_cnt2", pend_cnt_o, 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_cnt", pend_cnt_o, 0);
        chk("mid_rst_busy", init_busy_o, 1);
        chk("mid_rst_ready", ready_o, 0);
        chk("mid_rst_rd", |rd_o, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_init(n);
        chk("init_len2", n, 16);
        ra_tab[0:3] = '{5'd3, 5'd5, 5'd11, 5'd13};
        for (int i = 0; i < 4; i++) begin
            rdp(i, ra_tab[i], d);
            chk($sformatf("post_rst_r%0d", ra_tab[i]), d, 0);
        end
        @(negedge clk);
        chk("post_rst_cnt", pend_cnt_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
